// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: data width, destination codes
// and the 2-entry FIFO state encoding.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 8;

  localparam logic DEST_WB  = 1'b0;
  localparam logic DEST_LSU = 1'b1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry result FIFO with registered head/tail, full/empty flags and a
// modulo-256 count of completed output handshakes.
module result_fifo2
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [7:0]       xfer_count_o
);

  fifo_state_e      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             pop;

  assign pop = (state_q != EMPTY) && pop_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = pop ? cnt_q + 8'd1 : cnt_q;
    case (state_q)
      EMPTY: begin
        if (push_i) begin
          state_d = ONE;
          head_d  = push_data_i;
        end
      end
      ONE: begin
        // Simultaneous push and pop replaces the head and keeps one entry.
        if (push_i && pop) begin
          head_d = push_data_i;
        end else if (push_i) begin
          state_d = FULL;
          tail_d  = push_data_i;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o       = head_q;
  assign full_o       = (state_q == FULL);
  assign empty_o      = (state_q == EMPTY);
  assign xfer_count_o = cnt_q;

endmodule

// File: rtl/alu_result_demux.sv
// Steers each ALU result beat into the writeback (out0) or LSU (out1) FIFO;
// each destination buffers independently so one stalled consumer never blocks the other.
module alu_result_demux
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [7:0]       xfer_count0,
  output logic [7:0]       xfer_count1
);

  logic full0, full1;
  logic empty0, empty1;
  logic sel_full;
  logic accept;

  // Ready looks only at registered FIFO state, never at downstream ready.
  assign sel_full = (in_sel == DEST_LSU) ? full1 : full0;
  assign in_ready = !reset && !sel_full;
  assign accept   = in_valid && in_ready;

  result_fifo2 #(.WIDTH(WIDTH)) u_fifo0 (
    .clk          (clk),
    .reset        (reset),
    .push_i       (accept && (in_sel == DEST_WB)),
    .push_data_i  (in_data),
    .pop_ready_i  (out0_ready),
    .data_o       (out0_data),
    .full_o       (full0),
    .empty_o      (empty0),
    .xfer_count_o (xfer_count0)
  );

  result_fifo2 #(.WIDTH(WIDTH)) u_fifo1 (
    .clk          (clk),
    .reset        (reset),
    .push_i       (accept && (in_sel == DEST_LSU)),
    .push_data_i  (in_data),
    .pop_ready_i  (out1_ready),
    .data_o       (out1_data),
    .full_o       (full1),
    .empty_o      (empty1),
    .xfer_count_o (xfer_count1)
  );

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;

endmodule

// File: tb/tb_alu_result_demux.sv
// Bench for alu_result_demux: directed vector table, 256-beat wrap run and a
// randomized run against a queue-based reference model.
module tb_alu_result_demux;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       in_sel;
  logic [7:0] in_data;
  logic       out0_valid, out0_ready;
  logic [7:0] out0_data;
  logic       out1_valid, out1_ready;
  logic [7:0] out1_data;
  logic [7:0] xfer_count0, xfer_count1;

  int npass = 0;
  int ntot  = 0;

  alu_result_demux #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel      (in_sel),
    .in_data     (in_data),
    .out0_valid  (out0_valid),
    .out0_ready  (out0_ready),
    .out0_data   (out0_data),
    .out1_valid  (out1_valid),
    .out1_ready  (out1_ready),
    .out1_data   (out1_data),
    .xfer_count0 (xfer_count0),
    .xfer_count1 (xfer_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, v, sel;
    logic [7:0] d;
    logic       r0, r1;
    logic       e_rdy, e_v0;
    logic [7:0] e_d0;
    logic       e_v1;
    logic [7:0] e_d1;
    logic [7:0] e_c0, e_c1;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic r, input logic v, input logic s, input logic [7:0] d,
                       input logic r0, input logic r1);
    reset      = r;
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepting into a full buffer must never happen.
  always @(posedge clk) begin
    if (!reset && in_valid && in_ready) begin
      assert (!(in_sel ? dut.u_fifo1.full_o : dut.u_fifo0.full_o))
      else begin
        ntot++;
        $display("FAIL push_to_full: sel %0d accepted while buffer full", in_sel);
      end
    end
  end

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         c0, c1;
  logic       exp_rdy;

  initial begin
    //               rst   v     sel   d      r0    r1    rdy   v0    d0     v1    d1     c0    c1
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 8'd0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 8'd0, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 8'd0, 8'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 8'd0, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 8'hA5, 8'd0, 8'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 8'd0, 8'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 8'd0, 8'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 8'd1, 8'd1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd2, 8'd1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00, 8'd2, 8'd1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 8'h00, 8'd3, 8'd1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 8'h00, 8'd3, 8'd1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 8'h00, 8'd3, 8'd1};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 8'h44, 1'b1, 8'h66, 8'd3, 8'd1};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 8'h88, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 1'b1, 8'h66, 8'd3, 8'd1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0, 8'd0};

    // Reset values while reset is held.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_v0", out0_valid, 0);
    chk("rst_v1", out1_valid, 0);
    chk("rst_d0", out0_data, 0);
    chk("rst_d1", out1_data, 0);
    chk("rst_c0", xfer_count0, 0);
    chk("rst_c1", xfer_count1, 0);

    // Directed vectors: fill, cross-destination bypass, push+pop, mid-stream reset.
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("vec%0d_rdy", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_v0", i), out0_valid, tbl[i].e_v0);
      if (tbl[i].e_v0) chk($sformatf("vec%0d_d0", i), out0_data, tbl[i].e_d0);
      chk($sformatf("vec%0d_v1", i), out1_valid, tbl[i].e_v1);
      if (tbl[i].e_v1) chk($sformatf("vec%0d_d1", i), out1_data, tbl[i].e_d1);
      chk($sformatf("vec%0d_c0", i), xfer_count0, tbl[i].e_c0);
      chk($sformatf("vec%0d_c1", i), xfer_count1, tbl[i].e_c1);
      tick();
    end
    chk("post_rst_d0", out0_data, 0);
    chk("post_rst_d1", out1_data, 0);

    // 256 back-to-back beats to out0 with ready held high; counter wraps.
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'(i), 1'b1, 1'b0);
      #1;
      chk($sformatf("b2b%0d_rdy", i), in_ready, 1);
      if (i > 0) begin
        chk($sformatf("b2b%0d_v0", i), out0_valid, 1);
        chk($sformatf("b2b%0d_d0", i), out0_data, (i - 1) & 255);
        chk($sformatf("b2b%0d_c0", i), xfer_count0, (i - 1) & 255);
      end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    #1;
    chk("b2b_last_d0", out0_data, 8'hFF);
    tick();
    chk("b2b_wrap_c0", xfer_count0, 0);
    chk("b2b_empty_v0", out0_valid, 0);

    // Randomized traffic against the queue model, with occasional resets.
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    q0.delete();
    q1.delete();
    c0 = 0;
    c1 = 0;
    for (int n = 0; n < 10000; n++) begin
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
            8'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6));
      #1;
      exp_rdy = !reset && ((in_sel ? q1.size() : q0.size()) < 2);
      chk("rnd_rdy", in_ready, exp_rdy);
      chk("rnd_v0", out0_valid, q0.size() != 0);
      if (q0.size() != 0) chk("rnd_d0", out0_data, q0[0]);
      chk("rnd_v1", out1_valid, q1.size() != 0);
      if (q1.size() != 0) chk("rnd_d1", out1_data, q1[0]);
      chk("rnd_c0", xfer_count0, c0);
      chk("rnd_c1", xfer_count1, c1);
      if (reset) begin
        q0.delete();
        q1.delete();
        c0 = 0;
        c1 = 0;
      end else begin
        if (q0.size() != 0 && out0_ready) begin
          void'(q0.pop_front());
          c0 = (c0 + 1) % 256;
        end
        if (q1.size() != 0 && out1_ready) begin
          void'(q1.pop_front());
          c1 = (c1 + 1) % 256;
        end
        if (in_valid && exp_rdy) begin
          if (in_sel) q1.push_back(in_data);
          else q0.push_back(in_data);
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
